// File: rtl/programmable_timer.sv
// Prescaled compare timer with one-shot and periodic modes.
// Q is a registered one-cycle pulse on each expiry; C/pre/mode are captured at start.
module programmable_timer #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned PSC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] C,
    input  logic [PSC_W-1:0] pre,
    output logic             Q,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [PSC_W-1:0] r_psc;
    logic [WIDTH-1:0] r_c;
    logic [PSC_W-1:0] r_pre;
    logic             r_mode;
    logic             r_q;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [PSC_W-1:0] w_psc_nxt;
    logic [WIDTH-1:0] w_c_nxt;
    logic [PSC_W-1:0] w_pre_nxt;
    logic             w_mode_nxt;
    logic             w_q_nxt;
    logic             w_tick;
    logic             w_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_psc   <= '0;
            r_c     <= '0;
            r_pre   <= '0;
            r_mode  <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_psc   <= w_psc_nxt;
            r_c     <= w_c_nxt;
            r_pre   <= w_pre_nxt;
            r_mode  <= w_mode_nxt;
            r_q     <= w_q_nxt;
        end
    end

    // Priority: stop, then start (restarts from any state), then counting in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_psc_nxt   = r_psc;
        w_c_nxt     = r_c;
        w_pre_nxt   = r_pre;
        w_mode_nxt  = r_mode;
        w_q_nxt     = 1'b0;
        w_tick      = 1'b0;
        w_expire    = 1'b0;

        if (stop) begin
            w_state_nxt = ST_IDLE;
        end else if (start) begin
            w_state_nxt = ST_RUN;
            w_count_nxt = '0;
            w_psc_nxt   = '0;
            w_c_nxt     = C;
            w_pre_nxt   = pre;
            w_mode_nxt  = mode;
        end else if (r_state == ST_RUN && en) begin
            if (r_psc == r_pre) begin
                w_tick    = 1'b1;
                w_psc_nxt = '0;
            end else begin
                w_psc_nxt = r_psc + PSC_W'(1);
            end

            if (w_tick) begin
                if (r_count == r_c) begin
                    w_expire = 1'b1;
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end

            // One-shot parks at C_l in IDLE; periodic reloads and keeps running.
            if (w_expire) begin
                w_q_nxt = 1'b1;
                if (r_mode) begin
                    w_count_nxt = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

    assign Q     = r_q;
    assign busy  = (r_state == ST_RUN);
    assign count = r_count;

endmodule

// File: tb/tb_programmable_timer.sv
// Self-checking bench for programmable_timer: vector table, directed corner sequences
// and randomized stimulus compared against an elapsed-cycle arithmetic model.
module tb_programmable_timer;

    localparam int WIDTH = 6;
    localparam int PSC_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] C;
    logic [PSC_W-1:0] pre;
    logic             Q;
    logic             busy;
    logic [WIDTH-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    programmable_timer #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .C     (C),
        .pre   (pre),
        .Q     (Q),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    // Reference: elapsed enabled cycles since start; count = elapsed/(pre+1),
    // expiry when elapsed reaches (C+1)*(pre+1).
    bit m_run;
    bit m_q;
    bit m_mode;
    int m_e;
    int m_C;
    int m_pre;
    int m_count;

    task automatic model_reset();
        m_run = 0; m_q = 0; m_mode = 0; m_e = 0; m_C = 0; m_pre = 0; m_count = 0;
    endtask

    task automatic model_edge();
        int period;
        m_q = 0;
        if (stop) begin
            m_run = 0;
        end else if (start) begin
            m_run = 1; m_e = 0; m_count = 0;
            m_C = int'(C); m_pre = int'(pre); m_mode = mode;
        end else if (m_run && en) begin
            m_e++;
            period = (m_C + 1) * (m_pre + 1);
            if (m_e == period) begin
                m_q = 1;
                if (m_mode) begin
                    m_e = 0; m_count = 0;
                end else begin
                    m_run = 0; m_count = m_C;
                end
            end else begin
                m_count = m_e / (m_pre + 1);
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".Q"}, int'(Q), int'(m_q));
        check({tag, ".busy"}, int'(busy), int'(m_run));
        check({tag, ".count"}, int'(count), m_count);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input bit st, input bit sp, input bit e, input bit md,
                         input int c, input int p);
        start = st; stop = sp; en = e; mode = md;
        C = WIDTH'(c); pre = PSC_W'(p);
    endtask

    typedef struct {
        bit st; bit sp; bit en; bit md; int c; int p;
        bit eq; bit eb; int ecnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int first_q;
        int last_q;
        int n_q;
        int k;
        bit got;

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("reset.Q", int'(Q), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.count", int'(count), 0);

        // Inputs are ignored while reset is held
        drive(1, 0, 1, 1, 3, 0);
        cyc("rst_hold");
        cyc("rst_hold");
        drive(0, 0, 1, 0, 0, 0);
        rst = 1'b0;
        cyc("post_rst_idle");
        cyc("post_rst_idle");

        // One-shot C=4 pre=0, then start/stop priority and restart
        vecs = '{
            '{1,0,1,0,4,0, 0,1,0},
            '{0,0,1,1,9,7, 0,1,1},
            '{0,0,1,0,0,0, 0,1,2},
            '{0,0,1,0,0,0, 0,1,3},
            '{0,0,1,0,0,0, 0,1,4},
            '{0,0,1,0,0,0, 1,0,4},
            '{0,0,1,0,0,0, 0,0,4},
            '{0,0,0,0,0,0, 0,0,4},
            '{1,0,1,1,3,0, 0,1,0},
            '{0,0,1,1,3,0, 0,1,1},
            '{0,0,1,1,3,0, 0,1,2},
            '{1,1,1,1,3,0, 0,0,2},
            '{0,0,1,1,3,0, 0,0,2},
            '{0,0,1,1,3,0, 0,0,2},
            '{1,0,1,1,3,0, 0,1,0},
            '{0,0,1,1,3,0, 0,1,1},
            '{0,0,1,1,3,0, 0,1,2},
            '{1,0,1,1,3,0, 0,1,0},
            '{0,0,1,1,3,0, 0,1,1},
            '{0,0,1,1,3,0, 0,1,2},
            '{0,0,1,1,3,0, 0,1,3},
            '{0,0,1,1,3,0, 1,1,0},
            '{0,1,1,1,3,0, 0,0,0}
        };
        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].sp, vecs[i].en, vecs[i].md, vecs[i].c, vecs[i].p);
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("vec%0d.Q", i), int'(Q), int'(vecs[i].eq));
            check($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].eb));
            check($sformatf("vec%0d.count", i), int'(count), vecs[i].ecnt);
        end

        // Periodic C=2 pre=3: pulse every 12 cycles, busy held
        drive(1, 0, 1, 1, 2, 3);
        cyc("per_start");
        drive(0, 0, 1, 0, 7, 9);
        n_q = 0; first_q = -1; last_q = -1;
        for (int i = 1; i <= 36; i++) begin
            cyc("per");
            if (Q) begin
                if (first_q < 0) first_q = i;
                else check("per.interval", i - last_q, 12);
                last_q = i;
                n_q++;
            end
            check("per.busy_held", int'(busy), 1);
        end
        check("per.first_q", first_q, 12);
        check("per.n_q", n_q, 3);

        // en dropped for 4 cycles mid-run delays expiry by 4
        drive(1, 0, 1, 1, 3, 0);
        cyc("en_start");
        drive(0, 0, 1, 1, 3, 0);
        cyc("en_run");
        cyc("en_run");
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc("en_low");
            check("en_low.noQ", int'(Q), 0);
        end
        en = 1'b1;
        got = 0; k = 6;
        while (!got && k < 26) begin
            cyc("en_resume");
            k++;
            if (Q) got = 1;
        end
        check("en_delay.found", int'(got), 1);
        check("en_delay.edge", k, 8);

        // Asynchronous reset between edges mid-run
        drive(1, 0, 1, 1, 5, 1);
        cyc("arst_start");
        drive(0, 0, 1, 1, 5, 1);
        for (int i = 0; i < 5; i++) cyc("arst_run");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst.Q", int'(Q), 0);
        check("arst.busy", int'(busy), 0);
        check("arst.count", int'(count), 0);
        cyc("arst_hold");
        rst = 1'b0;
        n_q = 0;
        for (int i = 0; i < 20; i++) begin
            cyc("arst_after");
            if (Q) n_q++;
        end
        check("arst.noQ_after", n_q, 0);

        // C=0 pre=0 periodic: Q every cycle; C change during RUN ignored
        drive(1, 0, 1, 1, 0, 0);
        cyc("c0_start");
        drive(0, 0, 1, 1, 5, 0);
        for (int i = 0; i < 6; i++) begin
            cyc("c0_run");
            check("c0.Q_every", int'(Q), 1);
        end
        drive(1, 0, 1, 1, 5, 0);
        cyc("c5_restart");
        drive(0, 0, 1, 1, 5, 0);
        for (int i = 0; i < 7; i++) cyc("c5_run");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                model_reset();
                cyc("rnd_rst");
                rst = 1'b0;
            end
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7), $urandom_range(0, 3));
            cyc("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
